// File: rtl/cache_req_arbiter_if.sv
// cache_req_arbiter_if
// Bundles the two requester handshakes and the engine-side issue bus.
//   req0_*/req1_* : valid/addr/op from the requesters, ready back to them
//   cache_*       : registered address/op plus the one-cycle issue strobe
//   grant_id      : requester that owns the current issue
// Handshake rule: a request transfers on a rising edge where valid and
// ready are both high. While valid is high and ready is low the requester
// holds addr/op stable; valid may drop before acceptance with no effect.
// Modports: master = requester/engine side (drives requests, observes
// issue), slave = the arbiter.
interface cache_req_arbiter_if #(
    parameter int ADDR_W = 48
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [7:0]        req0_op;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [7:0]        req1_op;
    logic              req1_ready;
    logic [ADDR_W-1:0] cache_addr;
    logic [7:0]        cache_op;
    logic              cache_issue;
    logic              grant_id;

    modport master (
        output req0_valid, req0_addr, req0_op,
        output req1_valid, req1_addr, req1_op,
        input  req0_ready, req1_ready,
        input  cache_addr, cache_op, cache_issue, grant_id
    );

    modport slave (
        input  req0_valid, req0_addr, req0_op,
        input  req1_valid, req1_addr, req1_op,
        output req0_ready, req1_ready,
        output cache_addr, cache_op, cache_issue, grant_id
    );
endinterface

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter
// Round-robin arbiter between two trace requesters feeding cache_engine.
// Each legal request becomes one registered cache_addr/cache_op pair with
// a single-cycle cache_issue strobe, then GAP idle cycles. Requests with
// an op other than R/r/W/w are consumed, counted and never issued.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   bus (slave)   : requester handshakes and engine issue bus
//   busy          : FSM not in IDLE
//   req0_count    : legal requests issued for requester 0 (saturating)
//   req1_count    : legal requests issued for requester 1 (saturating)
//   bad_op_count  : requests dropped for an illegal op (saturating)
//   dbg_state     : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
module cache_req_arbiter #(
    parameter int ADDR_W = 48,
    parameter int GAP    = 4,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    cache_req_arbiter_if.slave bus,
    output logic              busy,
    output logic [CNT_W-1:0]  req0_count,
    output logic [CNT_W-1:0]  req1_count,
    output logic [CNT_W-1:0]  bad_op_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic              rr;
    logic [7:0]        wait_cnt;

    logic              sel;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_op;
    logic              sel_legal;

    function automatic logic is_legal(input logic [7:0] op);
        return (op == 8'h52) || (op == 8'h72) || (op == 8'h57) || (op == 8'h77);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Winner selection: a lone valid requester wins; with both valid the
    // round-robin pointer decides. Ready is only ever offered in IDLE and
    // is held low while reset is asserted so reset beats a handshake.
    always_comb begin
        sel = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            sel = rr;
        end else if (bus.req1_valid) begin
            sel = 1'b1;
        end
        accept         = (state == IDLE) && !reset && (bus.req0_valid || bus.req1_valid);
        bus.req0_ready = accept && !sel;
        bus.req1_ready = accept && sel;
        sel_addr       = sel ? bus.req1_addr : bus.req0_addr;
        sel_op         = sel ? bus.req1_op   : bus.req0_op;
        sel_legal      = is_legal(sel_op);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            rr              <= 1'b0;
            wait_cnt        <= 8'd0;
            busy            <= 1'b0;
            bus.cache_addr  <= '0;
            bus.cache_op    <= 8'd0;
            bus.cache_issue <= 1'b0;
            bus.grant_id    <= 1'b0;
            req0_count      <= '0;
            req1_count      <= '0;
            bad_op_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Pointer moves past the winner even for a dropped op.
                        rr <= !sel;
                        if (sel_legal) begin
                            bus.cache_addr  <= sel_addr;
                            bus.cache_op    <= sel_op;
                            bus.grant_id    <= sel;
                            bus.cache_issue <= 1'b1;
                            busy            <= 1'b1;
                            state           <= ISSUE;
                            if (sel) begin
                                req1_count <= sat_inc(req1_count);
                            end else begin
                                req0_count <= sat_inc(req0_count);
                            end
                        end else begin
                            bad_op_count <= sat_inc(bad_op_count);
                        end
                    end
                end
                ISSUE: begin
                    bus.cache_issue <= 1'b0;
                    if (GAP == 0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        // Counts GAP-1 down to 0, giving GAP cycles in WAIT.
                        state    <= WAIT;
                        wait_cnt <= 8'(GAP - 1);
                    end
                end
                WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                default: begin
                    state           <= IDLE;
                    busy            <= 1'b0;
                    bus.cache_issue <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb_cache_req_arbiter
// Directed bench for cache_req_arbiter. Instance dut_a uses GAP=4,
// instance dut_b uses GAP=0; both share clock and reset. Inputs change
// 1 time unit after the rising edge, outputs are sampled on the falling edge.
module tb_cache_req_arbiter;

    localparam int ADDR_W = 48;
    localparam int CNT_W  = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_req_arbiter_if #(.ADDR_W(ADDR_W)) bus_a ();
    cache_req_arbiter_if #(.ADDR_W(ADDR_W)) bus_b ();

    logic             busy_a, busy_b;
    logic [CNT_W-1:0] r0c_a, r1c_a, bad_a;
    logic [CNT_W-1:0] r0c_b, r1c_b, bad_b;
    logic [1:0]       st_a, st_b;

    cache_req_arbiter #(.ADDR_W(ADDR_W), .GAP(4), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .busy(busy_a),
        .req0_count(r0c_a), .req1_count(r1c_a), .bad_op_count(bad_a),
        .dbg_state(st_a)
    );

    cache_req_arbiter #(.ADDR_W(ADDR_W), .GAP(0), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .busy(busy_b),
        .req0_count(r0c_b), .req1_count(r1c_b), .bad_op_count(bad_b),
        .dbg_state(st_b)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus_a.req0_valid = 1'b0; bus_a.req0_addr = '0; bus_a.req0_op = 8'h00;
        bus_a.req1_valid = 1'b0; bus_a.req1_addr = '0; bus_a.req1_op = 8'h00;
        bus_b.req0_valid = 1'b0; bus_b.req0_addr = '0; bus_b.req0_op = 8'h00;
        bus_b.req1_valid = 1'b0; bus_b.req1_addr = '0; bus_b.req1_op = 8'h00;
    endtask

    // Leaves the caller at the start of the first cycle after reset.
    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy_a) break;
            next_cycle();
        end
        check("idle_a_timeout", busy_a, 0);
        next_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, nis, last, nb;
        reset = 1'b1;
        drive_idle();

        // ---- 1: reset values and a single read from requester 0 ----
        do_reset();
        @(negedge clk);
        check("rst_addr",  bus_a.cache_addr, 0);
        check("rst_op",    bus_a.cache_op, 0);
        check("rst_issue", bus_a.cache_issue, 0);
        check("rst_grant", bus_a.grant_id, 0);
        check("rst_busy",  busy_a, 0);
        check("rst_cnt0",  r0c_a, 0);
        check("rst_cnt1",  r1c_a, 0);
        check("rst_bad",   bad_a, 0);
        check("rst_ready0", bus_a.req0_ready, 0);
        next_cycle();
        bus_a.req0_valid = 1'b1;
        bus_a.req0_addr  = 48'h0000_1234_5678;
        bus_a.req0_op    = 8'h72;
        @(negedge clk);
        check("t1_ready0", bus_a.req0_ready, 1);
        check("t1_ready1", bus_a.req1_ready, 0);
        next_cycle();
        bus_a.req0_valid = 1'b0;
        @(negedge clk);
        check("t1_issue", bus_a.cache_issue, 1);
        check("t1_addr",  bus_a.cache_addr, 48'h0000_1234_5678);
        check("t1_op",    bus_a.cache_op, 8'h72);
        check("t1_grant", bus_a.grant_id, 0);
        check("t1_cnt0",  r0c_a, 1);
        nb = 0; nis = 0;
        if (busy_a) nb++;
        if (bus_a.cache_issue) nis++;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            @(negedge clk);
            if (busy_a) nb++;
            if (bus_a.cache_issue) nis++;
        end
        check("t1_busy_cycles", nb, 5);
        check("t1_issue_total", nis, 1);
        next_cycle();

        // ---- 2: both requesters valid, six legal requests ----
        do_reset();
        exp_q = {64'd0, 64'd1, 64'd0, 64'd1, 64'd0, 64'd1};
        hs = 0; nis = 0; last = -1;
        bus_a.req0_addr = 48'h0000_0000_00A0; bus_a.req0_op = 8'h52;
        bus_a.req1_addr = 48'h0000_0000_00B1; bus_a.req1_op = 8'h77;
        for (int c = 0; c < 50; c++) begin
            bus_a.req0_valid = (hs < 6);
            bus_a.req1_valid = (hs < 6);
            @(negedge clk);
            if (bus_a.req0_ready) hs++;
            if (bus_a.req1_ready) hs++;
            if (bus_a.cache_issue) begin
                if (exp_q.size() == 0) begin
                    check("t2_extra_issue", 1, 0);
                end else begin
                    logic [63:0] g;
                    g = exp_q.pop_front();
                    check("t2_grant", bus_a.grant_id, g);
                    check("t2_addr", bus_a.cache_addr, (g == 64'd1) ? 64'h00B1 : 64'h00A0);
                end
                if (last >= 0) check("t2_spacing", c - last, 6);
                last = c;
                nis++;
            end
            next_cycle();
        end
        bus_a.req0_valid = 1'b0;
        bus_a.req1_valid = 1'b0;
        check("t2_issue_total", nis, 6);
        check("t2_cnt0", r0c_a, 3);
        check("t2_cnt1", r1c_a, 3);
        check("t2_bad",  bad_a, 0);

        // ---- 3: illegal op from requester 1 ----
        do_reset();
        bus_a.req0_valid = 1'b1;
        bus_a.req0_addr  = 48'h0000_0000_C0DE;
        bus_a.req0_op    = 8'h57;
        @(negedge clk);
        check("t3_setup_ready0", bus_a.req0_ready, 1);
        next_cycle();
        bus_a.req0_valid = 1'b0;
        wait_idle_a();
        bus_a.req1_valid = 1'b1;
        bus_a.req1_addr  = 48'h0000_0000_DEAD;
        bus_a.req1_op    = 8'h5A;
        @(negedge clk);
        check("t3_ready1", bus_a.req1_ready, 1);
        check("t3_ready0", bus_a.req0_ready, 0);
        next_cycle();
        bus_a.req1_valid = 1'b0;
        @(negedge clk);
        check("t3_no_issue", bus_a.cache_issue, 0);
        check("t3_busy", busy_a, 0);
        check("t3_bad", bad_a, 1);
        check("t3_cnt1", r1c_a, 0);
        check("t3_addr_held", bus_a.cache_addr, 48'h0000_0000_C0DE);
        check("t3_op_held", bus_a.cache_op, 8'h57);
        next_cycle();
        bus_a.req0_valid = 1'b1; bus_a.req0_addr = 48'h0000_0000_1111; bus_a.req0_op = 8'h72;
        bus_a.req1_valid = 1'b1; bus_a.req1_addr = 48'h0000_0000_2222; bus_a.req1_op = 8'h52;
        @(negedge clk);
        check("t3_rr_ready0", bus_a.req0_ready, 1);
        check("t3_rr_ready1", bus_a.req1_ready, 0);
        next_cycle();
        bus_a.req0_valid = 1'b0;
        bus_a.req1_valid = 1'b0;
        @(negedge clk);
        check("t3_issue", bus_a.cache_issue, 1);
        check("t3_grant", bus_a.grant_id, 0);
        check("t3_addr", bus_a.cache_addr, 48'h0000_0000_1111);
        check("t3_cnt0", r0c_a, 2);
        next_cycle();

        // ---- 4: GAP=0, four back-to-back writes ----
        do_reset();
        hs = 0; nis = 0; last = -1;
        for (int c = 0; c < 16; c++) begin
            bus_b.req0_valid = (hs < 4);
            bus_b.req0_addr  = 48'h0000_0000_0100 + 48'(hs);
            bus_b.req0_op    = 8'h57;
            @(negedge clk);
            if (bus_b.req0_ready) hs++;
            if (bus_b.cache_issue) begin
                check("t4_addr", bus_b.cache_addr, 64'h100 + 64'(nis));
                check("t4_op", bus_b.cache_op, 8'h57);
                if (last >= 0) check("t4_spacing", c - last, 2);
                last = c;
                nis++;
            end
            next_cycle();
        end
        bus_b.req0_valid = 1'b0;
        check("t4_issue_total", nis, 4);
        check("t4_cnt0", r0c_b, 4);

        // ---- 5: reset during WAIT, then reset beating a handshake ----
        do_reset();
        bus_a.req0_valid = 1'b1;
        bus_a.req0_addr  = 48'h0000_0000_5555;
        bus_a.req0_op    = 8'h52;
        @(negedge clk);
        check("t5_ready0", bus_a.req0_ready, 1);
        next_cycle();
        bus_a.req0_valid = 1'b0;
        @(negedge clk);
        check("t5_issue", bus_a.cache_issue, 1);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("t5_in_wait", st_a, 2);
        next_cycle();
        reset = 1'b0;
        nb = 0; nis = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy_a) nb++;
            if (bus_a.cache_issue) nis++;
            next_cycle();
        end
        check("t5_abort_issue", nis, 0);
        check("t5_abort_busy", nb, 0);
        check("t5_cnt0", r0c_a, 0);
        check("t5_addr", bus_a.cache_addr, 0);
        reset = 1'b1;
        bus_a.req0_valid = 1'b1;
        next_cycle();
        reset = 1'b0;
        bus_a.req0_valid = 1'b0;
        @(negedge clk);
        check("t5_prio_issue", bus_a.cache_issue, 0);
        check("t5_prio_cnt0", r0c_a, 0);
        next_cycle();
        bus_a.req0_valid = 1'b1; bus_a.req0_addr = 48'h0000_0000_0AAA; bus_a.req0_op = 8'h77;
        bus_a.req1_valid = 1'b1; bus_a.req1_addr = 48'h0000_0000_0BBB; bus_a.req1_op = 8'h77;
        @(negedge clk);
        check("t5_post_ready0", bus_a.req0_ready, 1);
        check("t5_post_ready1", bus_a.req1_ready, 0);
        next_cycle();
        bus_a.req0_valid = 1'b0;
        bus_a.req1_valid = 1'b0;
        @(negedge clk);
        check("t5_post_grant", bus_a.grant_id, 0);
        check("t5_post_addr", bus_a.cache_addr, 48'h0000_0000_0AAA);
        next_cycle();

        // ---- 6: req0_count saturation (GAP=0 instance) ----
        do_reset();
        hs = 0;
        bus_b.req0_op = 8'h52;
        for (int c = 0; c < 9000 && hs < 4094; c++) begin
            bus_b.req0_valid = 1'b1;
            bus_b.req0_addr  = 48'(c);
            @(negedge clk);
            if (bus_b.req0_ready) hs++;
            next_cycle();
        end
        bus_b.req0_valid = 1'b0;
        check("t6_setup_hs", hs, 4094);
        repeat (2) next_cycle();
        @(negedge clk);
        check("t6_cnt_fffe", r0c_b, 12'hFFE);
        next_cycle();
        hs = 0; nis = 0;
        for (int c = 0; c < 20; c++) begin
            bus_b.req0_valid = (hs < 3);
            @(negedge clk);
            if (bus_b.req0_ready) hs++;
            if (bus_b.cache_issue) nis++;
            next_cycle();
        end
        bus_b.req0_valid = 1'b0;
        check("t6_issues", nis, 3);
        @(negedge clk);
        check("t6_cnt_sat", r0c_b, 12'hFFF);
        check("t6_cnt1", r1c_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Two-port request arbiter and issue sequencer in front of `cache_engine`. Accepts read/write requests from two independent trace requesters over valid/ready handshakes and grants them round-robin. Each granted request is presented to the engine as one `cache_addr`/`cache_op` pair with a single-cycle issue strobe, followed by a programmable settle gap. Requests with illegal op codes are consumed, counted and never issued.

## Interface
Parameters:
- `ADDR_W`, 48, address width; matches `cache_addr`.
- `GAP`, 4, idle cycles after each issue before the next accept; legal range 0..255.
- `CNT_W`, 12, width of the statistics counters.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1: requester 0 has a request.
- `req0_addr` in ADDR_W: requester 0 address.
- `req0_op` in 8: requester 0 op code (ASCII).
- `req0_ready` out 1: requester 0 request accepted this cycle.
- `req1_valid`, `req1_addr`, `req1_op`, `req1_ready`: same as requester 0, for requester 1.
- `cache_addr` out ADDR_W: address to the engine; registered.
- `cache_op` out 8: op to the engine; registered.
- `cache_issue` out 1: one-cycle strobe, engine consumes `cache_addr`/`cache_op`.
- `grant_id` out 1: requester that owns the current issue; registered.
- `busy` out 1: high when the state is not IDLE.
- `req0_count`, `req1_count` out CNT_W: legal requests issued per requester.
- `bad_op_count` out CNT_W: requests dropped for an illegal op.

## Operation
- Legal ops: 0x52 'R', 0x72 'r', 0x57 'W', 0x77 'w'. Legal ops are forwarded to `cache_op` unchanged.
- FSM states:
  - IDLE: selects a winner among the valid requesters and drives the winner's `ready` combinationally high. No other state asserts any `ready`.
  - ISSUE: `cache_issue`=1 for exactly one cycle.
  - WAIT: lasts GAP cycles.
- Winner selection:
  - One requester valid: it wins.
  - Both valid: the requester indicated by the round-robin pointer `rr` wins.
- Handshake is `reqN_valid & reqN_ready` in IDLE. On a handshake:
  - Legal op: latch addr, op and N into `cache_addr`, `cache_op`, `grant_id`; increment `reqN_count`; go to ISSUE.
  - Illegal op: increment `bad_op_count`; stay in IDLE; `cache_*` and `grant_id` unchanged.
  - In both cases `rr` becomes !N.
- ISSUE → WAIT when GAP>0, else ISSUE → IDLE.
- WAIT: an 8-bit down-counter loaded with GAP-1 on entry; the state exits to IDLE when the counter is 0.
- `cache_addr`, `cache_op` and `grant_id` hold their values until the next legal handshake.
- Counters saturate at all-ones and never wrap.
- Requester protocol: addr and op are held stable while valid is high and ready is low. Valid may be withdrawn before acceptance without effect.
- Reset values:
  - All outputs 0. `req0_ready`/`req1_ready` follow IDLE selection from the first cycle after reset.
  - `rr`=0, state IDLE, WAIT counter 0.
- Reset asserted in ISSUE or WAIT aborts immediately: no further strobe and no count change. Reset has priority over a same-cycle handshake.

## Timing
- Handshake at edge T → `cache_issue`=1 during cycle T+1 → earliest next handshake in cycle T+2+GAP.
- Legal request throughput: one per GAP+2 cycles. Illegal requests can be consumed one per cycle while in IDLE.
- `busy` rises in the cycle after a legal handshake and falls in the cycle the FSM returns to IDLE.
- Counters update on the edge that completes the handshake and are visible the next cycle.
- No combinational path from a requester input to any engine-side output.

## Test plan
- Reset, then only `req0_valid`=1 with addr 0x0000_1234_5678, op 0x72:
  - `req0_ready` in cycle 0 and `cache_issue` in cycle 1, with `cache_addr`=0x0000_1234_5678, `cache_op`=0x72, `grant_id`=0.
  - `busy` high for 5 cycles (GAP=4).
  - `req0_count`=1.
- Both requesters valid continuously, 6 legal requests: grants alternate 0,1,0,1,0,1; `cache_issue` every 6 cycles; each `reqN_count`=3.
- Requester 1 presents op 0x5A: `req1_ready` for one cycle, no `cache_issue`, `bad_op_count`=1, `cache_addr` unchanged, next grant goes to requester 0 when both are valid.
- GAP=0, single requester with 4 back-to-back writes (0x57): `cache_issue` pulses on alternate cycles, 4 total.
- Reset asserted during WAIT: no further `cache_issue`, all counters 0, the next request is granted to requester 0 when both are valid.
- Force `req0_count` to 0xFFE, then issue 3 requests: the count reads 0xFFF and stays there.
